// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage issue controller: opcode ranges,
// operand-size and op-class enums, opcode classification and size masking.
package alu_pkg;

    localparam int unsigned XLEN = 64;

    // Primary-opcode ranges, same encoding the ALU consumes.
    localparam logic [7:0] OPC_ADD_HI = 8'h05;
    localparam logic [7:0] OPC_OR_LO  = 8'h08;
    localparam logic [7:0] OPC_OR_HI  = 8'h0C;
    localparam logic [7:0] OPC_AND_LO = 8'h20;
    localparam logic [7:0] OPC_AND_HI = 8'h25;
    localparam logic [7:0] OPC_SUB_LO = 8'h28;
    localparam logic [7:0] OPC_SUB_HI = 8'h2C;
    localparam logic [7:0] OPC_XOR_LO = 8'h30;
    localparam logic [7:0] OPC_XOR_HI = 8'h35;
    localparam logic [7:0] OPC_CMP_LO = 8'h38;
    localparam logic [7:0] OPC_CMP_HI = 8'h3C;
    localparam logic [7:0] OPC_IMUL_A = 8'h69;
    localparam logic [7:0] OPC_IMUL_B = 8'h6B;

    typedef enum logic [1:0] {
        SZ_8  = 2'd0,
        SZ_16 = 2'd1,
        SZ_32 = 2'd2,
        SZ_64 = 2'd3
    } size_t;

    typedef enum logic [2:0] {
        CL_ADD   = 3'd0,
        CL_SUB   = 3'd1,
        CL_AND   = 3'd2,
        CL_OR    = 3'd3,
        CL_XOR   = 3'd4,
        CL_CMP   = 3'd5,
        CL_IMUL  = 3'd6,
        CL_UNSUP = 3'd7
    } op_class_t;

    // ADD range starts at 0x00, so only its upper bound needs testing.
    function automatic op_class_t classify(input logic [7:0] opcode);
        op_class_t cls;
        if (opcode <= OPC_ADD_HI) begin
            cls = CL_ADD;
        end else if (opcode >= OPC_OR_LO && opcode <= OPC_OR_HI) begin
            cls = CL_OR;
        end else if (opcode >= OPC_AND_LO && opcode <= OPC_AND_HI) begin
            cls = CL_AND;
        end else if (opcode >= OPC_SUB_LO && opcode <= OPC_SUB_HI) begin
            cls = CL_SUB;
        end else if (opcode >= OPC_XOR_LO && opcode <= OPC_XOR_HI) begin
            cls = CL_XOR;
        end else if (opcode >= OPC_CMP_LO && opcode <= OPC_CMP_HI) begin
            cls = CL_CMP;
        end else if (opcode == OPC_IMUL_A || opcode == OPC_IMUL_B) begin
            cls = CL_IMUL;
        end else begin
            cls = CL_UNSUP;
        end
        return cls;
    endfunction

    function automatic logic [XLEN-1:0] size_mask(input size_t size);
        logic [XLEN-1:0] m;
        case (size)
            SZ_8:    m = 64'h0000_0000_0000_00FF;
            SZ_16:   m = 64'h0000_0000_0000_FFFF;
            SZ_32:   m = 64'h0000_0000_FFFF_FFFF;
            SZ_64:   m = 64'hFFFF_FFFF_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// General-purpose register file: NREGS x W, cleared by reset, three
// combinational read ports (two operands plus debug) and one write port.
module alu_regfile #(
    parameter int NREGS = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] i_rd1_idx,
    output logic [W-1:0]             o_rd1_data,
    input  logic [$clog2(NREGS)-1:0] i_rd2_idx,
    output logic [W-1:0]             o_rd2_data,
    input  logic [$clog2(NREGS)-1:0] i_dbg_idx,
    output logic [W-1:0]             o_dbg_data,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata
);

    logic [W-1:0] r_regs [NREGS];

    // Storage: cleared on reset, single write per cycle otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rd1_data = r_regs[i_rd1_idx];
    assign o_rd2_data = r_regs[i_rd2_idx];
    assign o_dbg_data = r_regs[i_dbg_idx];

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue/writeback controller. Holds one decoded op in the E
// register, drives the external combinational ALU with size-masked operands,
// and retires the masked result into the GPR file and the ZF/SF flags.
// IMUL spends one extra cycle in MUL1 with its ALU inputs held stable.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_opcode,
    input  logic [3:0]   in_dst,
    input  logic [3:0]   in_src,
    input  logic [W-1:0] in_imm,
    input  logic         in_use_imm,
    input  logic [1:0]   in_size,
    output logic [W-1:0] alu_op1,
    output logic [W-1:0] alu_op2,
    output logic [7:0]   alu_oper,
    input  logic [W-1:0] alu_res,
    output logic         wb_valid,
    output logic [3:0]   wb_reg,
    output logic [W-1:0] wb_data,
    output logic         flag_zf,
    output logic         flag_sf,
    output logic         err_unsup,
    input  logic [3:0]   dbg_idx,
    output logic [W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_MUL1  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    // E register
    logic [7:0]   r_opcode;
    logic [3:0]   r_dst;
    logic [3:0]   r_src;
    logic [W-1:0] r_imm;
    logic         r_use_imm;
    size_t        r_size;

    // Registered retirement outputs
    logic         r_wb_valid;
    logic [3:0]   r_wb_reg;
    logic [W-1:0] r_wb_data;
    logic         r_zf;
    logic         r_sf;
    logic         r_err;

    logic         w_accept;
    logic         w_in_imul;
    op_class_t    w_class;
    logic         w_is_imul;
    logic         w_e_full;
    logic         w_retire;
    logic         w_writes;
    logic         w_we;
    logic         w_flag_upd;
    logic [3:0]   w_rd1_idx;
    logic [3:0]   w_rd2_idx;
    logic [W-1:0] w_rd1_data;
    logic [W-1:0] w_rd2_data;
    logic [W-1:0] w_mask;
    logic [W-1:0] w_op2_raw;
    logic [W-1:0] w_old_dst;
    logic [W-1:0] w_trunc;
    logic         w_sign;
    logic [W-1:0] w_wdata;

    assign in_ready  = (r_state == ST_EMPTY) || (r_state == ST_BUSY);
    assign w_accept  = in_valid && in_ready;
    assign w_in_imul = (classify(in_opcode) == CL_IMUL);

    assign w_class   = classify(r_opcode);
    assign w_is_imul = (w_class == CL_IMUL);
    assign w_e_full  = (r_state != ST_EMPTY);
    assign w_retire  = (r_state == ST_BUSY);
    assign w_writes  = (w_class != CL_CMP) && (w_class != CL_UNSUP);
    assign w_we      = w_retire && w_writes;
    assign w_flag_upd = w_retire && (w_class != CL_UNSUP);

    // IMUL takes op1 from src and its op2 is the immediate, which frees the
    // second read port to fetch the old dst value needed for partial merges.
    assign w_rd1_idx = w_is_imul ? r_src : r_dst;
    assign w_rd2_idx = w_is_imul ? r_dst : r_src;
    assign w_old_dst = w_is_imul ? w_rd2_data : w_rd1_data;
    assign w_op2_raw = (w_is_imul || r_use_imm) ? r_imm : w_rd2_data;
    assign w_mask    = size_mask(r_size);

    assign alu_op1  = w_e_full ? (w_rd1_data & w_mask) : '0;
    assign alu_op2  = w_e_full ? (w_op2_raw & w_mask) : '0;
    assign alu_oper = w_e_full ? r_opcode : 8'h00;

    assign w_trunc  = alu_res & w_mask;

    // Sign bit of the truncated result at the operand's top bit.
    always_comb begin
        w_sign = 1'b0;
        case (r_size)
            SZ_8:    w_sign = w_trunc[7];
            SZ_16:   w_sign = w_trunc[15];
            SZ_32:   w_sign = w_trunc[31];
            default: w_sign = w_trunc[W-1];
        endcase
    end

    // Write value: 8/16-bit ops keep the upper bits of dst, 32/64-bit ops
    // replace the whole register (32-bit zero-extends via the mask).
    always_comb begin
        w_wdata = w_trunc;
        case (r_size)
            SZ_8, SZ_16: w_wdata = (w_old_dst & ~w_mask) | w_trunc;
            default:     w_wdata = w_trunc;
        endcase
    end

    alu_regfile #(
        .NREGS (NREGS),
        .W     (W)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .i_rd1_idx  (w_rd1_idx),
        .o_rd1_data (w_rd1_data),
        .i_rd2_idx  (w_rd2_idx),
        .o_rd2_data (w_rd2_data),
        .i_dbg_idx  (dbg_idx),
        .o_dbg_data (dbg_data),
        .i_we       (w_we),
        .i_waddr    (r_dst),
        .i_wdata    (w_wdata)
    );

    // E-stage state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: BUSY retires and may accept in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY, ST_BUSY: begin
                if (w_accept) begin
                    if (w_in_imul) begin
                        w_next_state = ST_MUL1;
                    end else begin
                        w_next_state = ST_BUSY;
                    end
                end else begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_MUL1: w_next_state = ST_BUSY;
            default: w_next_state = ST_EMPTY;
        endcase
    end

    // E register: latches only on accept, held otherwise (including MUL1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode  <= 8'h00;
            r_dst     <= 4'd0;
            r_src     <= 4'd0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
            r_size    <= SZ_8;
        end else if (w_accept) begin
            r_opcode  <= in_opcode;
            r_dst     <= in_dst;
            r_src     <= in_src;
            r_imm     <= in_imm;
            r_use_imm <= in_use_imm;
            r_size    <= size_t'(in_size);
        end
    end

    // Retirement outputs: writeback pulse/data, flags and unsupported pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_reg   <= 4'd0;
            r_wb_data  <= '0;
            r_zf       <= 1'b0;
            r_sf       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wb_valid <= w_we;
            r_err      <= w_retire && (w_class == CL_UNSUP);
            if (w_we) begin
                r_wb_reg  <= r_dst;
                r_wb_data <= w_wdata;
            end
            if (w_flag_upd) begin
                r_zf <= (w_trunc == '0);
                r_sf <= w_sign;
            end
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_reg    = r_wb_reg;
    assign wb_data   = r_wb_data;
    assign flag_zf   = r_zf;
    assign flag_sf   = r_sf;
    assign err_unsup = r_err;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed ops push expected writebacks /
// unsupported retirements into queues; a negedge monitor pops and compares.
// A small behavioural ALU sits beside the DUT as its parent would.
module tb_alu_issue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_opcode;
    logic [3:0]  in_dst;
    logic [3:0]  in_src;
    logic [63:0] in_imm;
    logic        in_use_imm;
    logic [1:0]  in_size;
    logic [63:0] alu_op1;
    logic [63:0] alu_op2;
    logic [7:0]  alu_oper;
    logic [63:0] alu_res;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [63:0] wb_data;
    logic        flag_zf;
    logic        flag_sf;
    logic        err_unsup;
    logic [3:0]  dbg_idx;
    logic [63:0] dbg_data;

    typedef struct packed {
        logic [3:0]  rnum;
        logic [63:0] data;
        logic        zf;
        logic        sf;
    } exp_t;

    exp_t wbq[$];
    exp_t errq[$];
    int   total = 0;
    int   bad   = 0;
    int   waited;

    alu_issue dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_dst     (in_dst),
        .in_src     (in_src),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_size    (in_size),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_oper   (alu_oper),
        .alu_res    (alu_res),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .flag_zf    (flag_zf),
        .flag_sf    (flag_sf),
        .err_unsup  (err_unsup),
        .dbg_idx    (dbg_idx),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU.
    always_comb begin
        alu_res = 64'd0;
        if (alu_oper <= 8'h05) alu_res = alu_op1 + alu_op2;
        else if (alu_oper >= 8'h08 && alu_oper <= 8'h0C) alu_res = alu_op1 | alu_op2;
        else if (alu_oper >= 8'h20 && alu_oper <= 8'h25) alu_res = alu_op1 & alu_op2;
        else if (alu_oper >= 8'h28 && alu_oper <= 8'h2C) alu_res = alu_op1 - alu_op2;
        else if (alu_oper >= 8'h30 && alu_oper <= 8'h35) alu_res = alu_op1 ^ alu_op2;
        else if (alu_oper >= 8'h38 && alu_oper <= 8'h3C) alu_res = alu_op1 - alu_op2;
        else if (alu_oper == 8'h69 || alu_oper == 8'h6B) alu_res = alu_op1 * alu_op2;
        else alu_res = 64'hDEAD_BEEF_0000_0000;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [3:0] r, input logic [63:0] d, input logic zf, input logic sf);
        exp_t e;
        e.rnum = r; e.data = d; e.zf = zf; e.sf = sf;
        wbq.push_back(e);
    endtask

    task automatic expect_err(input logic zf, input logic sf);
        exp_t e;
        e.rnum = 4'd0; e.data = 64'd0; e.zf = zf; e.sf = sf;
        errq.push_back(e);
    endtask

    // Drive one op; called at posedge+1, returns at posedge+1 after accept.
    task automatic issue(input logic [7:0] opc, input logic [3:0] dst, input logic [3:0] src,
                         input logic [63:0] imm, input logic use_imm, input logic [1:0] size,
                         output int wait_cycles);
        wait_cycles = 0;
        in_valid = 1'b1; in_opcode = opc; in_dst = dst; in_src = src;
        in_imm = imm; in_use_imm = use_imm; in_size = size;
        while (!in_ready && wait_cycles < 20) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        if (wait_cycles >= 20) begin
            total++; bad++;
            $display("FAIL accept_timeout opcode=%h", opc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pop and compare on every writeback or unsupported pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid) begin
                if (wbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_wb actual_reg=%0d required=none", wb_reg);
                end else begin
                    exp_t e;
                    e = wbq.pop_front();
                    check("wb_reg", {60'd0, wb_reg}, {60'd0, e.rnum});
                    check("wb_data", wb_data, e.data);
                    check("wb_zf", {63'd0, flag_zf}, {63'd0, e.zf});
                    check("wb_sf", {63'd0, flag_sf}, {63'd0, e.sf});
                end
            end
            if (err_unsup) begin
                if (errq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_err actual=1 required=0");
                end else begin
                    exp_t e;
                    e = errq.pop_front();
                    check("err_zf", {63'd0, flag_zf}, {63'd0, e.zf});
                    check("err_sf", {63'd0, flag_sf}, {63'd0, e.sf});
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_opcode = 8'h00; in_dst = 4'd0; in_src = 4'd0;
        in_imm = 64'd0; in_use_imm = 1'b0; in_size = 2'd0; dbg_idx = 4'd0;
        step(3);
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_zf", {63'd0, flag_zf}, 64'd0);
        check("rst_sf", {63'd0, flag_sf}, 64'd0);
        check("rst_alu_op1", alu_op1, 64'd0);
        check("rst_alu_oper", {56'd0, alu_oper}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_idx = i[3:0]; #1;
            check("rst_dbg", dbg_data, 64'd0);
        end

        // ADD then SUB back-to-back, dependent on R1
        expect_wb(4'd1, 64'd5, 1'b0, 1'b0);
        issue(8'h05, 4'd1, 4'd0, 64'd5, 1'b1, 2'd3, waited);
        expect_wb(4'd1, 64'd0, 1'b1, 1'b0);
        issue(8'h2C, 4'd1, 4'd0, 64'd5, 1'b1, 2'd3, waited);
        check("b2b_wait", 64'(waited), 64'd0);

        // OR 64-bit, then 32-bit ADD zero-extends
        expect_wb(4'd2, 64'hFFFF_FFFF_0000_0001, 1'b0, 1'b1);
        issue(8'h0C, 4'd2, 4'd0, 64'hFFFF_FFFF_0000_0001, 1'b1, 2'd3, waited);
        expect_wb(4'd2, 64'd0, 1'b1, 1'b0);
        issue(8'h05, 4'd2, 4'd0, 64'h0000_0000_FFFF_FFFF, 1'b1, 2'd2, waited);

        // 8-bit ADD merges into low byte of R4
        expect_wb(4'd4, 64'h1234, 1'b0, 1'b0);
        issue(8'h05, 4'd4, 4'd0, 64'h1234, 1'b1, 2'd3, waited);
        expect_wb(4'd4, 64'h1233, 1'b0, 1'b0);
        issue(8'h04, 4'd4, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd0, waited);
        step(1);
        dbg_idx = 4'd2; #1;
        check("r2_zext", dbg_data, 64'd0);
        dbg_idx = 4'd4; #1;
        check("r4_merge", dbg_data, 64'h1233);

        // IMUL: R1=7, R3 = R1*6; follower waits exactly one cycle
        expect_wb(4'd1, 64'd7, 1'b0, 1'b0);
        issue(8'h05, 4'd1, 4'd0, 64'd7, 1'b1, 2'd3, waited);
        expect_wb(4'd3, 64'd42, 1'b0, 1'b0);
        issue(8'h6B, 4'd3, 4'd1, 64'd6, 1'b0, 2'd3, waited);
        check("mul1_in_ready", {63'd0, in_ready}, 64'd0);
        check("mul1_op1", alu_op1, 64'd7);
        check("mul1_op2", alu_op2, 64'd6);
        check("mul1_oper", {56'd0, alu_oper}, 64'h6B);
        expect_wb(4'd5, 64'd1, 1'b0, 1'b0);
        issue(8'h00, 4'd5, 4'd0, 64'd1, 1'b1, 2'd3, waited);
        check("mul_follow_wait", 64'(waited), 64'd1);
        step(1);
        dbg_idx = 4'd3; #1;
        check("r3_mul", dbg_data, 64'd42);

        // CMP: flags only
        issue(8'h3C, 4'd1, 4'd0, 64'd7, 1'b1, 2'd3, waited);
        step(1);
        check("cmp_zf", {63'd0, flag_zf}, 64'd1);
        check("cmp_wb_valid", {63'd0, wb_valid}, 64'd0);
        dbg_idx = 4'd1; #1;
        check("cmp_r1", dbg_data, 64'd7);

        // Unsupported opcode: error pulse, flags unchanged
        expect_err(1'b1, 1'b0);
        issue(8'h90, 4'd6, 4'd0, 64'd3, 1'b1, 2'd3, waited);
        step(3);
        dbg_idx = 4'd6; #1;
        check("unsup_r6", dbg_data, 64'd0);

        // Reset while in MUL1
        issue(8'h69, 4'd6, 4'd3, 64'd2, 1'b0, 2'd3, waited);
        check("pre_rst_mul1", {63'd0, in_ready}, 64'd0);
        reset = 1'b1; #1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_op1", alu_op1, 64'd0);
        check("midrst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("midrst_zf", {63'd0, flag_zf}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_idx = i[3:0]; #1;
            check("midrst_dbg", dbg_data, 64'd0);
        end
        step(2);
        reset = 1'b0;
        step(4);
        check("post_rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("wbq_empty", 64'(wbq.size()), 64'd0);
        check("errq_empty", 64'(errq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
